alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, registered integer ALU and the next generation of the team's 32-bit combinational ALU. It keeps the single-cycle logic/arithmetic ops and adds iterative unsigned multiply and divide, a Start/Busy/Done handshake, signed overflow and signed/unsigned compare. It sits in the execute stage and stalls the pipeline through `Busy` while a multi-cycle op runs.

## Interface
- `WIDTH`, 32: operand and result width; must be at least 4.
- `Clock` input 1: rising-edge clock.
- `Reset` input 1: asynchronous, active-high; forces `IDLE` and clears all outputs.
- `Start` input 1: request; sampled only in `IDLE`.
- `Op` input 3: operation code, captured with `Start`.
- `A`, `B` input WIDTH each: operands, captured with `Start`.
- `Result` output WIDTH: primary result.
- `ResultHi` output WIDTH: MUL high half or DIVU remainder; 0 for other ops.
- `CarryOut` output 1: ADD carry-out; SUB borrow (1 when A < B unsigned); 0 otherwise.
- `Overflow` output 1: signed overflow for ADD/SUB; 0 otherwise.
- `Zero` output 1: 1 when `Result` is 0.
- `DivZero` output 1: DIVU with B = 0.
- `Busy` output 1: high while in `RUN`.
- `Done` output 1: one-cycle pulse; all result outputs are valid and stay held until the next accepted `Start`.

## Operation
- Op encoding:
  - 000 AND; 001 OR; 010 ADD; 110 SUB.
  - 011 MUL: unsigned A×B, 2·WIDTH-bit product, low half on `Result`, high half on `ResultHi`.
  - 100 DIVU: unsigned; quotient on `Result`, remainder on `ResultHi`.
  - 101 SLTU: `Result` = 1 when A < B unsigned, else 0.
  - 111 SLT: `Result` = 1 when A < B signed (two's complement), else 0.
  - Any other code: `Result` = 0, all flags 0, completes like a single-cycle op.
- States: `IDLE`, `RUN`.
  - `IDLE` with `Start` and a single-cycle op: compute and register all outputs at that edge; stay in `IDLE`.
  - `IDLE` with `Start` and MUL, or DIVU with B ≠ 0: latch operands, load a counter with WIDTH, go to `RUN`.
  - `RUN`: one shift-add step (MUL) or one restoring shift-subtract step (DIVU) per cycle; counter decrements.
  - `RUN` with counter at 1: final step, register results and flags, return to `IDLE`.
- DIVU with B = 0 completes as a single-cycle op: `Result` all ones, `ResultHi` = A, `DivZero` = 1, `Zero` = 0.
- `Start` while `Busy` is ignored; the operands on the bus at that time are not captured.
- `Result`, `ResultHi` and the flags do not change mid-operation. The intermediate product or remainder lives in internal registers only.
- All arithmetic is modulo 2^WIDTH. Carry and borrow are taken from a WIDTH+1-bit sum or difference.
- Overflow:
  - ADD: operands have equal sign bits and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
- `DivZero` is 0 for every op except DIVU with B = 0.

## Timing
- Reset value of every output is 0, and state is `IDLE`.
- Single-cycle ops: `Start` sampled at edge k; outputs valid and `Done` = 1 in the cycle after edge k. Latency 1.
- MUL/DIVU: `Start` at edge k.
  - `Busy` = 1 from edge k to edge k+WIDTH.
  - Outputs valid and `Done` = 1 in the cycle after edge k+WIDTH. Latency WIDTH+1 cycles to `Done` (33 for WIDTH = 32).
- `Done` is high for exactly one cycle per accepted `Start`.
- Back-to-back: `Start` in the `Done` cycle is accepted, because the block is already in `IDLE`.
- Reset asserted mid-`RUN`:
  - Immediate return to `IDLE`, outputs cleared, no `Done`.
  - First `Start` after deassertion behaves normally.

## Test plan
All values use WIDTH = 32.
- AND and ADD: A=0xa5a5a5a5, B=0x5a5a5a5a.
  - AND -> `Result`=0, `Zero`=1, `Done` 1 cycle after `Start`.
  - ADD -> 0xffffffff, `CarryOut`=0.
- ADD/SUB flags:
  - 0xffffffff+1 -> `Result`=0, `CarryOut`=1, `Zero`=1, `Overflow`=0.
  - 0x7fffffff+1 -> 0x80000000, `Overflow`=1.
  - 5−7 -> 0xfffffffe, `CarryOut`=1.
- Compare: A=0x80000000, B=1.
  - SLT -> 1.
  - SLTU -> 0.
- MUL: 0xffffffff×0xffffffff.
  - `Busy` high 32 cycles, `Done` in cycle 33.
  - `ResultHi`=0xfffffffe, `Result`=0x00000001.
  - A `Start` pulsed mid-run is ignored.
- DIVU:
  - 100/7 -> `Result`=14, `ResultHi`=2 after 33 cycles.
  - 9/0 -> `Result`=0xffffffff, `ResultHi`=9, `DivZero`=1, latency 1.
- Reset at cycle 10 of a MUL:
  - Outputs 0, `Busy`=0, no `Done` pulse.
  - A following ADD 2+3 -> 5, `Done` 1 cycle later.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered integer ALU. Logic, add/sub and compare ops finish in one cycle.
// Unsigned multiply (shift-add) and divide (restoring) take WIDTH steps in RUN.
// Result outputs change only when an operation completes, and stay held until
// the next completion.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // opnd: multiplicand (MUL) or divisor (DIVU)
  // hi:   running product high half or partial remainder
  // lo:   multiplier being shifted out, or dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;

  // Single-cycle datapath, evaluated on the live operand bus.
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] r_c, hi_c;
  logic             c_c, v_c, dz_c, go_run;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};

  // Iterative step datapath, operating on the internal registers only.
  logic [WIDTH:0]   mul_add, div_sh, div_try;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_add = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_try = div_sh - {1'b0, opnd_q};
  // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
  assign div_ok  = ~div_try[WIDTH];

  // Pick the next partial product or partial remainder/quotient.
  always_comb begin
    step_hi = mul_add[WIDTH:1];
    step_lo = {mul_add[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      step_hi = div_ok ? div_try[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ok};
    end
  end

  // Decode the opcode into a single-cycle result or a request to iterate.
  always_comb begin
    r_c    = '0;
    hi_c   = '0;
    c_c    = 1'b0;
    v_c    = 1'b0;
    dz_c   = 1'b0;
    go_run = 1'b0;
    case (Op)
      OP_AND: r_c = A & B;
      OP_OR:  r_c = A | B;
      OP_ADD: begin
        r_c = sum_w[WIDTH-1:0];
        c_c = sum_w[WIDTH];
        v_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        r_c = diff_w[WIDTH-1:0];
        c_c = diff_w[WIDTH];
        v_c = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: r_c = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
      // Mixed signs: the negative operand is smaller; same signs: unsigned order holds.
      OP_SLT: r_c = {{(WIDTH-1){1'b0}},
                     (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : diff_w[WIDTH]};
      OP_MUL: go_run = 1'b1;
      OP_DIVU: begin
        if (B == '0) begin
          r_c  = '1;
          hi_c = A;
          dz_c = 1'b1;
        end else begin
          go_run = 1'b1;
        end
      end
      default: r_c = '0;
    endcase
  end

  // Next-state and next-output logic of the IDLE/RUN controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    divz_d      = divz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (go_run) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH);
            is_div_d = (Op == OP_DIVU);
            opnd_d   = (Op == OP_DIVU) ? B : A;
            lo_d     = (Op == OP_DIVU) ? A : B;
            hi_d     = '0;
          end else begin
            result_d    = r_c;
            result_hi_d = hi_c;
            carry_d     = c_c;
            ovf_d       = v_c;
            divz_d      = dz_c;
            zero_d      = (r_c == '0);
            done_d      = 1'b1;
          end
        end
      end
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = IDLE;
          result_d    = step_lo;
          result_hi_d = step_hi;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          divz_d      = 1'b0;
          zero_d      = (step_lo == '0);
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any running op without a Done.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      divz_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      divz_q      <= divz_d;
      done_q      <= done_d;
    end
  end

  assign Result   = result_q;
  assign ResultHi = result_hi_q;
  assign CarryOut = carry_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
  assign DivZero  = divz_q;
  assign Busy     = (state_q == RUN);
  assign Done     = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH = 32): directed vectors push
// hand-computed expectations; a monitor pops and compares on every Done.
module tb_alu_multicycle;

  logic        Clock, Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B, Result, ResultHi;
  logic        CarryOut, Overflow, Zero, DivZero, Busy, Done;

  alu_multicycle #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Result(Result), .ResultHi(ResultHi), .CarryOut(CarryOut),
    .Overflow(Overflow), .Zero(Zero), .DivZero(DivZero), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        c;
    logic        v;
    logic        z;
    logic        dz;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(Done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s result=%h hi=%h c=%b v=%b z=%b dz=%b lat=%0d",
                 e.name, Result, ResultHi, CarryOut, Overflow, Zero, DivZero,
                 cyc - e.issue_cyc);
        chk({e.name, ".result"},   Result,          e.res);
        chk({e.name, ".hi"},       ResultHi,        e.hi);
        chk({e.name, ".carry"},    32'(CarryOut),   32'(e.c));
        chk({e.name, ".overflow"}, 32'(Overflow),   32'(e.v));
        chk({e.name, ".zero"},     32'(Zero),       32'(e.z));
        chk({e.name, ".divzero"},  32'(DivZero),    32'(e.dz));
        chk({e.name, ".latency"},  32'(cyc - e.issue_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue(string nm, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] res, logic [31:0] hi,
                       logic c, logic v, logic z, logic dz, int lat);
    exp_t e;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    e.name = nm; e.res = res; e.hi = hi; e.c = c; e.v = v; e.z = z; e.dz = dz;
    e.lat = lat; e.issue_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    Reset = 1'b1; Start = 1'b0; Op = 3'b000; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    chk("reset.result", Result, 32'd0);
    chk("reset.hi", ResultHi, 32'd0);
    chk("reset.flags", {26'd0, CarryOut, Overflow, Zero, DivZero, Busy, Done}, 32'd0);
    Reset = 1'b0;

    // Single-cycle ops: name, op, A, B, result, hi, carry, ovf, zero, divzero, latency
    issue("and",      3'b000, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0,        32'h0, 0, 0, 1, 0, 1); drain();
    issue("add",      3'b010, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 32'h0, 0, 0, 0, 0, 1); drain();
    issue("add_wrap", 3'b010, 32'hffffffff, 32'h1,        32'h0,        32'h0, 1, 0, 1, 0, 1); drain();
    issue("add_ovf",  3'b010, 32'h7fffffff, 32'h1,        32'h80000000, 32'h0, 0, 1, 0, 0, 1); drain();
    issue("sub_brw",  3'b110, 32'd5,        32'd7,        32'hfffffffe, 32'h0, 1, 0, 0, 0, 1); drain();
    issue("sub_ovf",  3'b110, 32'h80000000, 32'h1,        32'h7fffffff, 32'h0, 0, 1, 0, 0, 1); drain();
    issue("slt",      3'b111, 32'h80000000, 32'h1,        32'h1,        32'h0, 0, 0, 0, 0, 1); drain();
    issue("sltu",     3'b101, 32'h80000000, 32'h1,        32'h0,        32'h0, 0, 0, 1, 0, 1); drain();
    issue("slt_neg",  3'b111, 32'hfffffffe, 32'hffffffff, 32'h1,        32'h0, 0, 0, 0, 0, 1); drain();
    issue("div0",     3'b100, 32'd9,        32'd0,        32'hffffffff, 32'd9, 0, 0, 0, 1, 1); drain();

    // Back-to-back: second Start lands in the Done cycle of the first
    issue("or_b2b",   3'b001, 32'hf0f00000, 32'h00000f0f, 32'hf0f00f0f, 32'h0, 0, 0, 0, 0, 1);
    issue("sub_b2b",  3'b110, 32'd3,        32'd3,        32'h0,        32'h0, 0, 0, 1, 0, 1);
    drain();

    // MUL with Busy count and a Start pulsed mid-run that must be ignored
    issue("mul_max",  3'b011, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'hfffffffe, 0, 0, 0, 0, 33);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      Start = (i == 10);
      Op = 3'b010; A = 32'd1; B = 32'd1;
      if (Busy) busy_cnt++;
      else break;
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    drain();

    issue("mul_sh",   3'b011, 32'h12345678, 32'h10,       32'h23456780, 32'h1, 0, 0, 0, 0, 33); drain();
    issue("divu",     3'b100, 32'd100,      32'd7,        32'd14,       32'd2, 0, 0, 0, 0, 33); drain();
    issue("divu_max", 3'b100, 32'hffffffff, 32'h10,       32'h0fffffff, 32'hf, 0, 0, 0, 0, 33); drain();

    // Reset ten cycles into a MUL: outputs clear, no Done afterwards
    issue("mul_abort", 3'b011, 32'hffffffff, 32'hffffffff, 32'h1, 32'hfffffffe, 0, 0, 0, 0, 33);
    repeat (10) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    sb.delete();
    Reset = 1'b1;
    #1;
    chk("abort.result", Result, 32'd0);
    chk("abort.hi", ResultHi, 32'd0);
    chk("abort.flags", {26'd0, CarryOut, Overflow, Zero, DivZero, Busy, Done}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    chk("abort.no_done", 32'(done_cnt), 32'd0);
    issue("add_after", 3'b010, 32'd2, 32'd3, 32'd5, 32'h0, 0, 0, 0, 0, 1); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
